tero_sample_packer: RTL
=======================

# tero_sample_packer

Packs 8-bit TERO oscillation-count samples into 32-bit words for the UART sender. It sits between the TERO RNG core (DIN/WE) and the UART sender (DOUT/OE/UART_READY). It offers three output formats: raw counts, a raw LSB bitstream, and per-4096-sample statistics (sum and sum of squares).

## Interface
- `STAT_LOG2`, default 12: log2 of the samples per statistics block (4096).
- `CLK` in 1: system clock, 100 MHz.
- `RST` in 1: reset, synchronous, active-high.
- `MODE` in 2: output format.
  - `01`: counts.
  - `11`: LSBs.
  - `x0`: statistics.
- `UART_READY` in 1: the sender can accept a word this cycle.
- `DIN` in 8: oscillation count of one TERO trial.
- `WE` in 1: DIN valid; single-cycle pulse.
- `DOUT` out 32: packed word; valid only while OE is high.
- `OE` out 1: word-write strobe to the sender; single cycle.
- `OVF` out 1: sticky flag, set when a completed word could not be queued.

## Operation
- **Mode latch:** `mode_r` is loaded from MODE whenever the packer is empty (no partial word, no pending output). MODE changes at other times take effect at the next empty point.
- **Counts mode (01):** 4 samples per word. The first sample goes to DOUT[31:24] and the fourth to DOUT[7:0].
- **LSB mode (11):** DIN[0] of 32 samples per word. The first sample goes to DOUT[31], the 32nd to DOUT[0].
- **Statistics mode (x0), per sample:** `sum += DIN` (20 bits) and `sq += DIN*DIN` (28 bits).
  - The square is registered one stage before accumulation.
  - Widths are exact: 4096·255 < 2^20 and 4096·255² < 2^28, so there is no saturation logic.
- **Statistics mode, after the 4096th sample:** two words are produced, in this order:
  - `{4'hA, 8'h00, sum}`
  - `{4'hB, sq}`
  - Both accumulators and the sample counter then clear.
- **Output queue:** a 2-entry FIFO of completed words.
  - Head pops with OE=1 in any cycle where UART_READY=1 and the queue is non-empty.
  - If a word completes while the queue is full, the word is dropped, OVF is set, and the packing counters restart at zero.
  - OVF clears only on RST.
- **FSM states:**
  - `IDLE`: empty; latches MODE; moves to `FILL` on the first WE.
  - `FILL`: collecting samples.
  - `EMIT`: completion cycle; pushes one word, or two in statistics mode.
  - `EMIT` returns to `FILL`, or to `IDLE` if the queue is empty afterwards.

## Timing
- **Reset values:** DOUT=0, OE=0, OVF=0, queue empty, all counters and accumulators 0, state `IDLE`.
- **Input rate:** WE may be high at most every second cycle; every WE pulse is consumed.
- **Counts/LSB latency:** the completing WE at cycle t pushes the word at t+1. The earliest OE is t+2.
- **Statistics latency:** the last WE at t gives the square at t+1, accumulation at t+2, and the sum word pushed at t+3. The sq word is pushed at t+4.
- **Simultaneous push and pop:** a push to a full queue in the same cycle as a pop succeeds, with no OVF.
- **Counter wrap:** the sample counter is STAT_LOG2 bits and wraps 4095 → 0 exactly at word completion.
- **RST mid-word:** the partial word and queued words are discarded, with no OE.

## Structure
- **Shared package (with the top):** localparams
  - `MODE_CNT=2'b01`, `MODE_LSB=2'b11`, and a stats-mode test on `MODE[0]==0`
  - `TAG_SUM=4'hA`, `TAG_SQ=4'hB`
- **Sub-module:** `word_queue2`, the 2-deep, 32-bit FIFO with full/empty flags and same-cycle push/pop.
- **Top-level contents:** the FSM, packing shift registers and statistics datapath live in this module.

## Test plan
- **Counts mode:** MODE=01; DIN 0x11, 0x22, 0x33, 0x44 on WE every 2nd cycle; UART_READY=1 → one OE with DOUT=0x11223344, two cycles after the 4th WE.
- **LSB mode:** MODE=11; 32 samples alternating DIN=0x01, 0x00 → DOUT=0xAAAAAAAA.
- **Statistics mode:** MODE=00; 4096 samples of DIN=0xFF → two OEs, DOUT=0xA00FF000 then 0xBFE01000 (sq = 266,342,400 = 0xFE01000).
- **Backpressure:** MODE=01; UART_READY=0 while 3 words complete → first two words are retained and OVF=1. Raising UART_READY then pops both in order.
- **Simultaneous push and pop:** queue full and UART_READY rising in the same cycle as a completion → no OVF, and words come out in order.
- **RST mid-word:** RST after 2 samples in counts mode → no OE. The next 4 samples form a fresh word.

Source files
------------

// File: rtl/tero_sample_packer_pkg.sv
// Shared constants and types for the TERO sample packer: mode codes, word tags,
// datapath widths and the packer FSM state encoding.
package tero_sample_packer_pkg;

   localparam logic [1:0] MODE_CNT = 2'b01;
   localparam logic [1:0] MODE_LSB = 2'b11;

   localparam logic [3:0] TAG_SUM = 4'hA;
   localparam logic [3:0] TAG_SQ  = 4'hB;

   localparam int WORD_W = 32;
   localparam int SUM_W  = 20;
   localparam int SQ_W   = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      EMIT = 2'd2
   } state_t;

   // Any mode with bit 0 clear selects the statistics format.
   function automatic logic is_stat_mode(input logic [1:0] m);
      return ~m[0];
   endfunction

endpackage

// File: rtl/tero_sample_packer_word_queue2.sv
// Two-entry, 32-bit word FIFO with full/empty flags; a push into a full queue
// is accepted when a pop happens in the same cycle.
module word_queue2
   import tero_sample_packer_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic              push_ok,
   output logic [WORD_W-1:0] head,
   output logic              full,
   output logic              empty
);

   logic [WORD_W-1:0] mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        count;
   logic              do_pop;
   logic              do_push;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign push_ok = do_push;
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (RST) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tero_sample_packer.sv
// Packs 8-bit TERO counts into 32-bit UART words: raw counts, raw LSB stream,
// or per-block sum / sum-of-squares statistics, through a 2-word output queue.
module tero_sample_packer
   import tero_sample_packer_pkg::*;
#(
   parameter int STAT_LOG2 = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [1:0]        MODE,
   input  logic              UART_READY,
   input  logic [7:0]        DIN,
   input  logic              WE,
   output logic [WORD_W-1:0] DOUT,
   output logic              OE,
   output logic              OVF
);

   state_t                 state;
   state_t                 state_nxt;
   logic [1:0]             mode_r;
   logic [1:0]             mode_eff;
   logic                   stat_eff;
   logic                   stat_r;
   logic [STAT_LOG2-1:0]   cnt;
   logic [STAT_LOG2-1:0]   cnt_max;
   logic                   cnt_at_max;
   logic [WORD_W-1:0]      shreg;

   logic                   p1_v;
   logic                   p1_last;
   logic [7:0]             p1_din;
   logic [15:0]            p1_sq;
   logic                   acc_done;
   logic [SUM_W-1:0]       sum;
   logic [SQ_W-1:0]        sq;
   logic [SQ_W-1:0]        sq_hold;
   logic                   emit_phase;

   logic                   push;
   logic [WORD_W-1:0]      push_data;
   logic                   push_ok;
   logic                   q_full;
   logic                   q_empty;
   logic                   word_done;
   logic                   drained;
   logic                   ovf_r;

   // In IDLE the packer is empty, so the incoming sample already uses MODE.
   assign mode_eff   = (state == IDLE) ? MODE : mode_r;
   assign stat_eff   = is_stat_mode(mode_eff);
   assign stat_r     = is_stat_mode(mode_r);
   assign cnt_at_max = (cnt == cnt_max);

   always_comb begin
      cnt_max = '1;
      if (!stat_eff) begin
         cnt_max = (mode_eff == MODE_CNT) ? STAT_LOG2'(3) : STAT_LOG2'(31);
      end
   end

   assign word_done = stat_r ? acc_done : (WE && cnt_at_max);
   assign drained   = !WE && (cnt == '0) && !p1_v && !acc_done && q_empty;

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (WE) state_nxt = FILL;
         FILL: begin
            if (word_done) begin
               state_nxt = EMIT;
            end else if (drained) begin
               state_nxt = IDLE;
            end
         end
         EMIT: begin
            if (stat_r && !emit_phase) begin
               state_nxt = EMIT;
            end else begin
               state_nxt = FILL;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs toward the queue
   always_comb begin
      push      = 1'b0;
      push_data = shreg;
      if (state == EMIT) begin
         push = 1'b1;
         if (stat_r) begin
            push_data = emit_phase ? {TAG_SQ, sq_hold} : {TAG_SUM, 8'h00, sum};
         end
      end
   end

   // Packing datapath and statistics pipeline
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_r     <= 2'b00;
         cnt        <= '0;
         shreg      <= '0;
         p1_v       <= 1'b0;
         p1_last    <= 1'b0;
         p1_din     <= 8'd0;
         p1_sq      <= 16'd0;
         acc_done   <= 1'b0;
         sum        <= '0;
         sq         <= '0;
         sq_hold    <= '0;
         emit_phase <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         if (state == IDLE) begin
            mode_r <= MODE;
         end
         if (WE) begin
            cnt <= cnt_at_max ? '0 : cnt + STAT_LOG2'(1);
            if (mode_eff == MODE_LSB) begin
               shreg <= {shreg[WORD_W-2:0], DIN[0]};
            end else begin
               shreg <= {shreg[WORD_W-9:0], DIN};
            end
         end
         p1_v     <= WE && stat_eff;
         p1_last  <= WE && stat_eff && cnt_at_max;
         p1_din   <= DIN;
         p1_sq    <= 16'(DIN) * 16'(DIN);
         acc_done <= p1_v && p1_last;

         // The sum word leaves this cycle; snapshot sq and restart both
         // accumulators, folding in a sample of the next block if present.
         if (state == EMIT && stat_r && !emit_phase) begin
            sq_hold <= sq;
            sum     <= p1_v ? SUM_W'(p1_din) : '0;
            sq      <= p1_v ? SQ_W'(p1_sq) : '0;
         end else if (p1_v) begin
            sum <= sum + SUM_W'(p1_din);
            sq  <= sq + SQ_W'(p1_sq);
         end
         emit_phase <= (state == EMIT) && stat_r && !emit_phase;

         if (push && !push_ok) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign OE  = UART_READY & ~q_empty;
   assign OVF = ovf_r;

   word_queue2 u_queue (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push),
      .push_data (push_data),
      .pop       (OE),
      .push_ok   (push_ok),
      .head      (DOUT),
      .full      (q_full),
      .empty     (q_empty)
   );

endmodule
